bitxor_query_ctrl: RTL and testbench

//  Sequencer in front of the 8-entry 1-bit XOR register file (prefix-XOR read port).

---
 rtl/bitxor_pkg.sv | 18 +
 rtl/bitxor_query_ctrl.sv | 118 +++++++++++
 tb/tb_bitxor_query_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bitxor_pkg.sv
// Shared constants for the 1-bit XOR register file and its query sequencer.
package bitxor_pkg;

    localparam logic [1:0] INST_WRITE = 2'b00;
    localparam logic [1:0] INST_READ  = 2'b01;

    localparam logic OP_UPDATE = 1'b0;
    localparam logic OP_QUERY  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UPD  = 3'd1,
        S_QHI  = 3'd2,
        S_QLO  = 3'd3,
        S_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/bitxor_query_ctrl.sv
// Sequencer for the prefix-XOR register file: point updates, and range queries
// computed as prefix(hi) ^ prefix(lo-1) over two read cycles.
module bitxor_query_ctrl
    import bitxor_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [IDX_W-1:0] cmd_lo,
    input  logic [IDX_W-1:0] cmd_hi,
    input  logic             cmd_val,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_data,
    output logic             rsp_err,
    output logic [1:0]       reg_inst,
    output logic [IDX_W-1:0] reg_idx,
    output logic             reg_xorval,
    input  logic             reg_rangexor
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             val_q, val_d;
    logic             acc_q, acc_d;
    logic             rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        val_d      = val_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        reg_inst   = INST_READ;
        reg_idx    = '0;
        reg_xorval = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    lo_d  = cmd_lo;
                    hi_d  = cmd_hi;
                    val_d = cmd_val;
                    if (cmd_op == OP_UPDATE) begin
                        state_d = S_UPD;
                    end else if (cmd_lo > cmd_hi) begin
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 1'b0;
                    end else begin
                        state_d   = S_QHI;
                        rsp_err_d = 1'b0;
                    end
                end
            end
            S_UPD: begin
                reg_inst   = INST_WRITE;
                reg_idx    = lo_q;
                reg_xorval = val_q;
                state_d    = S_IDLE;
            end
            S_QHI: begin
                reg_idx = hi_q;
                acc_d   = reg_rangexor;
                // lo==0 needs no second read: the prefix already is the range
                if (lo_q != '0) begin
                    state_d = S_QLO;
                end else begin
                    state_d    = S_RESP;
                    rsp_data_d = reg_rangexor;
                end
            end
            S_QLO: begin
                reg_idx    = lo_q - IDX_W'(1);
                rsp_data_d = acc_q ^ reg_rangexor;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            val_q      <= 1'b0;
            acc_q      <= 1'b0;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            val_q      <= val_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bitxor_query_ctrl.sv
// Bench for bitxor_query_ctrl with a behavioural 8-entry prefix-XOR register file.
module tb_bitxor_query_ctrl;
    import bitxor_pkg::*;

    localparam int IDX_W = 3;
    localparam int N     = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_op, cmd_val;
    logic [IDX_W-1:0] cmd_lo, cmd_hi;
    logic             rsp_valid, rsp_ready, rsp_data, rsp_err;
    logic [1:0]       reg_inst;
    logic [IDX_W-1:0] reg_idx;
    logic             reg_xorval, reg_rangexor;

    int tests = 0;
    int fails = 0;
    int writes = 0;
    int stray = 0;
    int refc[N];

    always #5 clk = ~clk;

    bitxor_query_ctrl #(.IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_val(cmd_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .reg_inst(reg_inst), .reg_idx(reg_idx), .reg_xorval(reg_xorval),
        .reg_rangexor(reg_rangexor)
    );

    // register file environment model
    logic [N-1:0] cells = '0;
    always_comb begin
        reg_rangexor = 1'b0;
        for (int i = 0; i < N; i++)
            if (i <= int'(reg_idx)) reg_rangexor = reg_rangexor ^ cells[i];
    end
    always @(posedge clk)
        if (reg_inst == INST_WRITE) cells[reg_idx] <= cells[reg_idx] ^ reg_xorval;

    always @(negedge clk) begin
        if (reg_inst == INST_WRITE) writes++;
        if (reg_inst != INST_WRITE && reg_xorval) stray++;
        if (reg_inst != INST_WRITE && reg_inst != INST_READ) stray++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_q(input int lo, input int hi);
        int x = 0;
        if (lo > hi) return 0;
        for (int i = lo; i <= hi; i++) x ^= refc[i];
        return x;
    endfunction

    task automatic update(input int lo, input int val);
        cmd_op = OP_UPDATE; cmd_lo = lo[IDX_W-1:0]; cmd_hi = '0; cmd_val = val[0];
        cmd_valid = 1'b1;
        chk("upd_cmd_ready", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk("upd_busy", int'(cmd_ready), 0);
        tick();
        refc[lo] ^= val;
    endtask

    task automatic query(input int lo, input int hi, input int hold, input int exp_d, input int exp_e);
        int lat;
        int exp_lat;
        int d0;
        exp_lat = (lo > hi) ? 1 : (lo == 0) ? 2 : 3;
        cmd_op = OP_QUERY; cmd_lo = lo[IDX_W-1:0]; cmd_hi = hi[IDX_W-1:0]; cmd_val = 1'b0;
        cmd_valid = 1'b1;
        chk("q_cmd_ready", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("q_latency", lat, exp_lat);
        chk("q_data", int'(rsp_data), exp_d);
        chk("q_err", int'(rsp_err), exp_e);
        d0 = int'(rsp_data);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_data", int'(rsp_data), d0);
            chk("hold_ready", int'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("q_released", int'(rsp_valid), 0);
    endtask

    typedef struct {
        logic op;
        int   lo, hi, val;
        int   exp_d, exp_e;
    } vec_t;

    initial begin
        vec_t vt[$];
        int   w0;
        int   lo, hi;
        logic [N-1:0] refv;

        foreach (refc[i]) refc[i] = 0;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 1'b0; cmd_lo = '0; cmd_hi = '0; cmd_val = 1'b0;
        tick(); tick();
        rst = 1'b0;

        for (int c = 0; c < 5; c++) begin
            chk("rst_cmd_ready", int'(cmd_ready), 1);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_reg_inst", int'(reg_inst), int'(INST_READ));
            chk("rst_outputs", int'({rsp_data, rsp_err, reg_xorval, reg_idx}), 0);
            tick();
        end
        chk("rst_no_writes", writes, 0);

        vt = '{
            '{OP_UPDATE, 3, 0, 1, 0, 0},
            '{OP_QUERY,  3, 3, 0, 1, 0},
            '{OP_UPDATE, 3, 0, 1, 0, 0},
            '{OP_UPDATE, 0, 0, 1, 0, 0},
            '{OP_UPDATE, 2, 0, 1, 0, 0},
            '{OP_UPDATE, 5, 0, 1, 0, 0},
            '{OP_QUERY,  0, 7, 0, 1, 0},
            '{OP_QUERY,  1, 4, 0, 1, 0},
            '{OP_QUERY,  1, 5, 0, 0, 0},
            '{OP_QUERY,  6, 7, 0, 0, 0},
            '{OP_QUERY,  7, 7, 0, 0, 0},
            '{OP_QUERY,  0, 0, 0, 1, 0}
        };
        foreach (vt[i]) begin
            if (vt[i].op == OP_UPDATE) update(vt[i].lo, vt[i].val);
            else query(vt[i].lo, vt[i].hi, 0, vt[i].exp_d, vt[i].exp_e);
        end

        // error query must not touch the file
        w0 = writes;
        query(5, 2, 0, 0, 1);
        chk("err_no_write", writes - w0, 0);

        // backpressure with a competing command waiting
        w0 = writes;
        cmd_op = OP_QUERY; cmd_lo = 3'd1; cmd_hi = 3'd4; cmd_valid = 1'b1;
        tick();
        cmd_op = OP_UPDATE; cmd_lo = 3'd6; cmd_val = 1'b1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_data", int'(rsp_data), 1);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_ready_after", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        refc[6] ^= 1;
        tick();
        chk("bp_one_write", writes - w0, 1);

        // reset while in QLO drops the query
        cmd_op = OP_QUERY; cmd_lo = 3'd2; cmd_hi = 3'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstq_cmd_ready", int'(cmd_ready), 1);
        chk("rstq_rsp_valid", int'(rsp_valid), 0);
        tick();
        chk("rstq_still_quiet", int'(rsp_valid), 0);
        query(2, 5, 0, ref_q(2, 5), 0);

        // randomized traffic against the reference array
        for (int n = 0; n < 300; n++) begin
            lo = int'($urandom_range(N - 1));
            hi = int'($urandom_range(N - 1));
            if ($urandom_range(2) == 0) update(lo, int'($urandom_range(1)));
            else query(lo, hi, int'($urandom_range(3) == 0 ? $urandom_range(3) : 0),
                       ref_q(lo, hi), (lo > hi) ? 1 : 0);
        end

        for (int i = 0; i < N; i++) refv[i] = refc[i][0];
        chk("final_cells", int'(cells), int'(refv));
        chk("no_stray_writes", stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
